// File: rtl/fc_pkg.sv
// Shared types for the fully-connected weight sequencer: FSM state encoding
// and the default accumulator width.
package fc_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, EMIT} fc_state_e;
  localparam int FC_ACC_W = 32;
endpackage

// File: rtl/fc_weight_sequencer_if.sv
// Bus bundle for fc_weight_sequencer: control handshake, weight/activation
// memory read ports and the result stream.
interface fc_weight_sequencer_if
  import fc_pkg::*;
#(
  parameter int NUM_IN  = 400,
  parameter int NUM_OUT = 120,
  parameter int ACC_W   = FC_ACC_W
) ();
  localparam int AW = $clog2(NUM_IN*NUM_OUT);
  localparam int IW = $clog2(NUM_IN);
  localparam int JW = $clog2(NUM_OUT);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic [AW-1:0]           rom_addr;
  logic signed [7:0]       rom_q;
  logic [IW-1:0]           act_addr;
  logic signed [7:0]       act_q;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [JW-1:0]           out_idx;

  modport master (
    input  start, rom_q, act_q, out_ready,
    output busy, done, rom_addr, act_addr, out_valid, out_data, out_idx
  );
  modport slave (
    output start, rom_q, act_q, out_ready,
    input  busy, done, rom_addr, act_addr, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/fc_mac_unit.sv
// Signed 8x8 multiply-accumulate; the 16-bit product is sign-extended and the
// accumulator wraps. clear wins over enable.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int ACC_W = FC_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [15:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (enable)  acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/fc_weight_sequencer.sv
// Walks the weight matrix one neuron at a time, streams each dot product out
// with a valid/ready handshake. Define FC_RELU_EN to clamp results at zero.
module fc_weight_sequencer
  import fc_pkg::*;
#(
  parameter int NUM_IN  = 400,
  parameter int NUM_OUT = 120,
  parameter int ACC_W   = FC_ACC_W
) (
  input logic clk,
  input logic rst,
  fc_weight_sequencer_if.master bus
);
  localparam int AW = $clog2(NUM_IN*NUM_OUT);
  localparam int IW = $clog2(NUM_IN);
  localparam int JW = $clog2(NUM_OUT);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_IN-1);
  localparam logic [JW-1:0] J_LAST = JW'(NUM_OUT-1);

  fc_state_e               state, nxt;
  logic [IW-1:0]           i;
  logic [JW-1:0]           j;
  logic [AW-1:0]           base;
  logic [AW-1:0]           rom_addr;
  logic [IW-1:0]           act_addr;
  logic                    mac_vld;
  logic                    done;
  logic                    accept, xfer, last_i, last_j, mac_clr;
  logic signed [ACC_W-1:0] acc;

  // A start landing on the done cycle would otherwise re-launch immediately.
  assign accept  = (state == IDLE) && bus.start && !done;
  assign xfer    = (state == EMIT) && bus.out_ready;
  assign last_i  = (i == I_LAST);
  assign last_j  = (j == J_LAST);
  assign mac_clr = accept || (xfer && !last_j);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) nxt = FETCH;
      FETCH: if (last_i) nxt = DRAIN;
      DRAIN: nxt = EMIT;
      EMIT:  if (xfer)   nxt = last_j ? IDLE : FETCH;
    endcase
  end

  // Address registers are loaded one edge ahead so each FETCH cycle presents
  // base+i; they are left untouched outside FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      j        <= '0;
      base     <= '0;
      rom_addr <= '0;
      act_addr <= '0;
      mac_vld  <= 1'b0;
      done     <= 1'b0;
    end else begin
      mac_vld <= (state == FETCH);
      done    <= xfer && last_j;
      case (state)
        IDLE: if (accept) begin
          i        <= '0;
          j        <= '0;
          base     <= '0;
          rom_addr <= '0;
          act_addr <= '0;
        end
        FETCH: if (!last_i) begin
          i        <= i + IW'(1);
          rom_addr <= base + AW'(i) + AW'(1);
          act_addr <= i + IW'(1);
        end
        EMIT: if (xfer && !last_j) begin
          j        <= j + JW'(1);
          i        <= '0;
          base     <= base + AW'(NUM_IN);
          rom_addr <= base + AW'(NUM_IN);
          act_addr <= '0;
        end
        default: ;
      endcase
    end
  end

  fc_mac_unit #(.ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clr),
    .enable (mac_vld),
    .a      (bus.rom_q),
    .b      (bus.act_q),
    .acc    (acc)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.rom_addr  = rom_addr;
  assign bus.act_addr  = act_addr;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_idx   = j;
`ifdef FC_RELU_EN
  assign bus.out_data  = acc[ACC_W-1] ? '0 : acc;
`else
  assign bus.out_data  = acc;
`endif
endmodule

// File: tb/tb_fc_weight_sequencer.sv
// Randomized bench for fc_weight_sequencer (NUM_IN=4, NUM_OUT=3) with 1-cycle
// memory models and a dot-product reference model.
module tb_fc_weight_sequencer;
  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 3;
  localparam int ACC_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fc_weight_sequencer_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ACC_W(ACC_W)) bus ();

  fc_weight_sequencer #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [7:0] wmem [16];
  logic signed [7:0] amem [NUM_IN];

  always @(posedge clk) begin
    bus.rom_q <= wmem[bus.rom_addr];
    bus.act_q <= amem[bus.act_addr];
  end

  // observation queues
  logic [31:0] xd[$];
  int          xi[$];
  int          xc[$];
  int          raq[$];
  int          aaq[$];
  int          done_cnt, done_cyc, fv_cyc, last_r, last_a;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      xd.push_back(bus.out_data);
      xi.push_back(int'(bus.out_idx));
      xc.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fv_cyc < 0 && bus.out_valid) fv_cyc = cyc;
    if (bus.busy) begin
      if (int'(bus.rom_addr) != last_r) begin raq.push_back(int'(bus.rom_addr)); last_r = int'(bus.rom_addr); end
      if (int'(bus.act_addr) != last_a) begin aaq.push_back(int'(bus.act_addr)); last_a = int'(bus.act_addr); end
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_out(input int k);
    longint s = 0;
    logic signed [31:0] r;
    for (int n = 0; n < NUM_IN; n++)
      s += longint'(wmem[k*NUM_IN+n]) * longint'(amem[n]);
    r = s[31:0];
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic fill(input int mode);
    for (int n = 0; n < 16; n++)
      case (mode)
        0: wmem[n] = 8'sd1;
        1: wmem[n] = -8'sd128;
        2: wmem[n] = -8'sd1;
        3: wmem[n] = 8'(n);
        default: wmem[n] = 8'($urandom);
      endcase
    for (int n = 0; n < NUM_IN; n++)
      case (mode)
        1: amem[n] = -8'sd128;
        4: amem[n] = 8'($urandom);
        default: amem[n] = 8'sd1;
      endcase
  endtask

  task automatic begin_pass();
    xd.delete(); xi.delete(); xc.delete(); raq.delete(); aaq.delete();
    done_cnt = 0; done_cyc = 0; fv_cyc = -1; last_r = -1; last_a = -1;
  endtask

  task automatic check_results();
    int nerr;
    chk("xfer_count", xd.size(), NUM_OUT);
    for (int k = 0; k < xd.size() && k < NUM_OUT; k++) begin
      chk("out_data", xd[k], ref_out(k));
      chk("out_idx", xi[k], k);
    end
    chk("done_count", done_cnt, 1);
    if (xc.size() > 0) chk("done_gap", done_cyc - xc[$], 1);
    nerr = 0;
    for (int k = 0; k < NUM_IN*NUM_OUT; k++) begin
      if (k >= raq.size() || raq[k] != k) nerr++;
      if (k >= aaq.size() || aaq[k] != k % NUM_IN) nerr++;
    end
    chk("addr_seq_len", raq.size() + aaq.size(), 2*NUM_IN*NUM_OUT);
    chk("addr_seq_err", nerr, 0);
  endtask

  task automatic pulse_start(output int start_cyc);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic do_pass(input bit rnd, input bit poke, input bit chk_lat);
    int guard, sc;
    bit last_seen;
    begin_pass();
    bus.out_ready = 1'b1;
    pulse_start(sc);
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      last_seen = (xi.size() > 0) && (xi[$] == NUM_OUT-1);
      if (rnd)  bus.out_ready = 1'($urandom_range(0, 1));
      if (poke) bus.start = last_seen ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      guard++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    chk("pass_finished", guard < 400, 1);
    if (chk_lat) chk("first_valid_lat", fv_cyc - sc + 1, 6);
    check_results();
  endtask

  task automatic stall_pass();
    int guard, sc;
    bit stalled, bad_v, bad_d, bad_a;
    logic [31:0] d0;
    int i0, r0, a0;
    begin_pass();
    bus.out_ready = 1'b0;
    stalled = 0; bad_v = 0; bad_d = 0; bad_a = 0;
    pulse_start(sc);
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) begin
        if (bus.out_idx == 1 && !stalled) begin
          stalled = 1;
          d0 = bus.out_data; i0 = int'(bus.out_idx);
          r0 = int'(bus.rom_addr); a0 = int'(bus.act_addr);
          repeat (10) begin
            @(negedge clk);
            bad_v |= !bus.out_valid;
            bad_d |= (bus.out_data != d0) || (int'(bus.out_idx) != i0);
            bad_a |= (int'(bus.rom_addr) != r0) || (int'(bus.act_addr) != a0);
          end
          chk("stall_valid_held", bad_v, 0);
          chk("stall_data_held", bad_d, 0);
          chk("stall_no_new_addr", bad_a, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
      end
    end
    chk("stall_pass_finished", guard < 400, 1);
    chk("stall_seen", stalled, 1);
    bus.out_ready = 1'b1;
    check_results();
  endtask

  task automatic abort_pass();
    int guard, sc;
    begin_pass();
    bus.out_ready = 1'b1;
    pulse_start(sc);
    guard = 0;
    while (xd.size() == 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reached_n1", xd.size(), 1);
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_data", bus.out_data, 0);
    chk("abort_idx", bus.out_idx, 0);
    chk("abort_rom_addr", bus.rom_addr, 0);
    chk("abort_act_addr", bus.act_addr, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_more_xfer", xd.size(), 1);
  endtask

  initial begin
    int busy_cnt;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    fill(0);
    begin_pass();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_act_addr", bus.act_addr, 0);
    @(posedge clk); #1 rst = 1'b0;

    fill(0); do_pass(0, 0, 1);
    fill(1); do_pass(0, 0, 0);
    fill(2); do_pass(0, 0, 0);
    fill(3); do_pass(0, 0, 0);
    fill(4); stall_pass();
    fill(4); abort_pass();
    fill(4); do_pass(0, 0, 1);

    fill(4); do_pass(1, 1, 0);
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    chk("retrig_ignored", busy_cnt, 0);
    chk("retrig_xfers", xd.size(), NUM_OUT);

    for (int r = 0; r < 3; r++) begin
      fill(4);
      do_pass(1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fc_weight_sequencer.md
FC_WEIGHT_SEQUENCER -- requirements
Module: fc_weight_sequencer

Interface
REQ-001 Parameter NUM_IN, default 400: inputs per output neuron.
REQ-002 Parameter NUM_OUT, default 120: output neurons; weight memory depth = NUM_IN*NUM_OUT.
REQ-003 Parameter ACC_W, default 32: accumulator and result width.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle request to run one full layer pass.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse after the last neuron result is accepted.
REQ-009 rom_addr  out  $clog2(NUM_IN*NUM_OUT)  weight memory address; data returns on rom_q one cycle later.
REQ-010 rom_q  in  8  signed weight.
REQ-011 act_addr  out  $clog2(NUM_IN)  activation buffer address; data returns on act_q one cycle later.
REQ-012 act_q  in  8  signed activation.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-015 out_data  out  ACC_W  signed neuron result.
REQ-016 out_idx  out  $clog2(NUM_OUT)  neuron index of out_data.

Function
REQ-017 FSM states IDLE, FETCH, DRAIN, EMIT; IDLE->FETCH on start, with neuron j=0, input i=0, accumulator cleared.
REQ-018 FETCH: each cycle drive rom_addr=j*NUM_IN+i and act_addr=i, then increment i; after i=NUM_IN-1 go to DRAIN.
REQ-019 Address generation uses a running base register (base += NUM_IN per neuron), no multiplier.
REQ-020 A one-cycle valid flag tracks issued addresses; when set, acc += rom_q*act_q (16-bit signed product, sign-extended to ACC_W, wrap on overflow).
REQ-021 DRAIN: one cycle absorbing the final product, then EMIT; per-neuron compute latency = NUM_IN+1 cycles from entering FETCH.
REQ-022 EMIT: out_valid=1, out_data and out_idx=j held stable until out_ready; on transfer, if j<NUM_OUT-1 then j++, i=0, acc cleared, go to FETCH; else pulse done and go to IDLE.
REQ-023 out_ready is ignored outside EMIT; out_valid never depends combinationally on out_ready.
REQ-024 start is ignored while busy; start coincident with the done pulse is ignored.
REQ-025 rom_addr and act_addr hold their last value outside FETCH; memory contents are read-only from this block.

Reset
REQ-026 On rst: state IDLE; busy, done, out_valid = 0; out_data, out_idx, rom_addr, act_addr, i, j, base, acc = 0.
REQ-027 rst asserted mid-pass aborts immediately, emits no partial result, and produces no done pulse.
REQ-028 rst has priority over start in the same cycle.

Configuration
REQ-029 Macro FC_RELU_EN: when defined, out_data = max(acc,0); when undefined, out_data = acc unmodified; no other behaviour changes.

Structure
REQ-030 Shared package fc_pkg holds the state enum (IDLE, FETCH, DRAIN, EMIT) and the default ACC_W constant.
REQ-031 Sub-module fc_mac_unit (clear, enable, two signed 8-bit operands, ACC_W accumulator) is instantiated once; the sequencer owns the FSM and counters.
REQ-032 Target size: 120-400 lines of RTL total.

Verification (bench: NUM_IN=4, NUM_OUT=3, memory models with 1-cycle read latency)
REQ-033 All weights 1, activations 1, out_ready=1 -> three results of 4, idx 0,1,2; done 1 cycle after the third transfer; first out_valid 6 cycles after start.
REQ-034 Weights and activations all -128 -> each result 65536; all weights -1 and activations 1 -> -4 without FC_RELU_EN, 0 with it.
REQ-035 out_ready held low 10 cycles in EMIT of neuron 1 -> out_valid, out_data and out_idx stable; no new addresses issued; resumes on ready.
REQ-036 rst pulsed during FETCH of neuron 1 -> all outputs 0 next cycle, no done pulse; a new start yields a correct full pass.
REQ-037 start re-pulsed while busy and on the done cycle -> ignored; exactly NUM_OUT transfers per accepted start.
REQ-038 Weight memory loaded with its address value -> rom_addr sequence is 0..11 in order, act_addr cycles 0..3 per neuron.
